// File: rtl/led_fader_pkg.sv
// Shared types for the multi-channel LED fader: fade mode encoding.
package led_fader_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        FADE_CONST    = 2'd0,
        FADE_TRIANGLE = 2'd1,
        FADE_SAW      = 2'd2,
        FADE_BLINK    = 2'd3
    } mode_t;

endpackage

// File: rtl/led_fader_channel.sv
// One fade generator: latched config, fade-rate divider and level sequencer.
module led_fader_channel
    import led_fader_pkg::*;
#(
    parameter int W      = 8,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena_i,
    input  logic              fade_tick_i,
    input  logic              sync_i,
    input  logic              wr_i,
    input  mode_t             mode_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic [W-1:0]      level_i,
    output logic [W-1:0]      level_o
);

    localparam logic [W-1:0] MAX = '1;

    mode_t             mode_q, mode_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
    logic [W-1:0]      on_level_q, on_level_d;
    logic [W-1:0]      level_q, level_d;
    logic              up_q, up_d;
    logic              fade_step;

    // NOTE: every variable gets its default first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        mode_d     = mode_q;
        rate_d     = rate_q;
        rate_cnt_d = rate_cnt_q;
        on_level_d = on_level_q;
        level_d    = level_q;
        up_d       = up_q;
        fade_step  = 1'b0;

        if (ena_i && fade_tick_i) begin
            if (rate_cnt_q == rate_q) begin
                rate_cnt_d = '0;
                fade_step  = 1'b1;
            end else begin
                rate_cnt_d = rate_cnt_q + 1'b1;
            end
        end

        if (fade_step) begin
            case (mode_q)
                FADE_TRIANGLE: begin
                    if (up_q) begin
                        if (level_q == MAX) begin
                            level_d = MAX - 1'b1;
                            up_d    = 1'b0;
                        end else begin
                            level_d = level_q + 1'b1;
                        end
                    end else begin
                        if (level_q == '0) begin
                            level_d = W'(1);
                            up_d    = 1'b1;
                        end else begin
                            level_d = level_q - 1'b1;
                        end
                    end
                end
                FADE_SAW:   level_d = (level_q == MAX) ? '0 : level_q + 1'b1;
                FADE_BLINK: level_d = (level_q == '0) ? on_level_q : '0;
                default:    level_d = level_q;
            endcase
        end

        // A config write restarts the phase itself; otherwise sync beats a coincident fade step.
        if (wr_i) begin
            mode_d     = mode_i;
            rate_d     = rate_i;
            on_level_d = level_i;
            level_d    = (mode_i == FADE_CONST) ? level_i : '0;
            up_d       = 1'b1;
            rate_cnt_d = '0;
        end else if (sync_i && (mode_q != FADE_CONST)) begin
            level_d    = '0;
            up_d       = 1'b1;
            rate_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mode_q     <= FADE_CONST;
            rate_q     <= '0;
            rate_cnt_q <= '0;
            on_level_q <= '0;
            level_q    <= '0;
            up_q       <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            rate_q     <= rate_d;
            rate_cnt_q <= rate_cnt_d;
            on_level_q <= on_level_d;
            level_q    <= level_d;
            up_q       <= up_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/multi_channel_led_fader.sv
// N fade generators driving a shared-counter PWM bank with period-aligned duty updates.
module multi_channel_led_fader
    import led_fader_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PWM_WIDTH = 8,
    parameter int RATE_W    = 8
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic                          step,
    input  logic                          fade_tick,
    input  logic                          sync,
    input  logic                          cfg_wr,
    input  logic [3:0]                    cfg_ch,
    input  logic [MODE_W-1:0]             cfg_mode,
    input  logic [RATE_W-1:0]             cfg_rate,
    input  logic [PWM_WIDTH-1:0]          cfg_level,
    output logic                          cfg_err,
    output logic [CHANNELS-1:0]           pwm_out,
    output logic [CHANNELS*PWM_WIDTH-1:0] levels,
    output logic                          period_start
);

    localparam int           W        = PWM_WIDTH;
    localparam logic [W-1:0] MAX      = '1;
    localparam logic [4:0]   CH_LIMIT = 5'(CHANNELS);

    logic [W-1:0]        pwm_cnt_q, pwm_cnt_d;
    logic [W-1:0]        duty_act_q [CHANNELS];
    logic [W-1:0]        level      [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                cfg_err_q, period_start_q;
    logic                pwm_adv, pwm_wrap, cfg_bad;

    assign pwm_adv   = ena && step;
    assign pwm_wrap  = pwm_adv && (pwm_cnt_q == MAX - 1'b1);
    assign cfg_bad   = {1'b0, cfg_ch} >= CH_LIMIT;
    assign pwm_cnt_d = pwm_wrap ? '0 : (pwm_adv ? pwm_cnt_q + 1'b1 : pwm_cnt_q);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_fader_channel #(
            .W      (W),
            .RATE_W (RATE_W)
        ) u_ch (
            .clk         (clk),
            .rstb        (rstb),
            .ena_i       (ena),
            .fade_tick_i (fade_tick),
            .sync_i      (sync && ena),
            .wr_i        (cfg_wr && (cfg_ch == 4'(i))),
            .mode_i      (mode_t'(cfg_mode)),
            .rate_i      (cfg_rate),
            .level_i     (cfg_level),
            .level_o     (level[i])
        );

        assign levels[i*W +: W] = level[i];
        assign pwm_d[i]         = ena ? (pwm_cnt_q < duty_act_q[i]) : pwm_q[i];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pwm_cnt_q      <= '0;
            pwm_q          <= '0;
            cfg_err_q      <= 1'b0;
            period_start_q <= 1'b0;
            // NOTE: duty_act is a small bank of flops, not a RAM, so it is safe to reset.
            for (int i = 0; i < CHANNELS; i++) duty_act_q[i] <= '0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            pwm_q          <= pwm_d;
            cfg_err_q      <= cfg_wr && cfg_bad;
            period_start_q <= pwm_wrap;
            // Duty only changes as the counter returns to 0, so no PWM period is ever cut short.
            if (pwm_wrap) begin
                for (int i = 0; i < CHANNELS; i++) duty_act_q[i] <= level[i];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign cfg_err      = cfg_err_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_multi_channel_led_fader.sv
// Scoreboard bench: a closed-form fader model predicts every cycle; a monitor compares on the falling edge.
module tb_multi_channel_led_fader;

    localparam int CH   = 4;
    localparam int W    = 4;
    localparam int RW   = 8;
    localparam int MAXV = (1 << W) - 1;

    logic              clk, rstb, ena, step, fade_tick, sync, cfg_wr;
    logic [3:0]        cfg_ch;
    logic [1:0]        cfg_mode;
    logic [RW-1:0]     cfg_rate;
    logic [W-1:0]      cfg_level;
    logic              cfg_err, period_start;
    logic [CH-1:0]     pwm_out;
    logic [CH*W-1:0]   levels;

    multi_channel_led_fader #(
        .CHANNELS  (CH),
        .PWM_WIDTH (W),
        .RATE_W    (RW)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .ena          (ena),
        .step         (step),
        .fade_tick    (fade_tick),
        .sync         (sync),
        .cfg_wr       (cfg_wr),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_rate     (cfg_rate),
        .cfg_level    (cfg_level),
        .cfg_err      (cfg_err),
        .pwm_out      (pwm_out),
        .levels       (levels),
        .period_start (period_start)
    );

    typedef struct {
        logic [CH*W-1:0] levels;
        logic [CH-1:0]   pwm;
        logic            err;
        logic            ps;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: per-channel config plus count of effective fade ticks since the last phase restart.
    int            m_mode [CH];
    int            m_rate [CH];
    int            m_lvl  [CH];
    int            m_t    [CH];
    int            m_duty [CH];
    int            m_cnt;
    logic [CH-1:0] m_pwm;
    logic          m_err, m_ps;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Level after k = t/(rate+1) fade steps, straight from the mode definitions.
    function automatic int level_of(input int i);
        int k, r;
        k = m_t[i] / (m_rate[i] + 1);
        case (m_mode[i])
            1: begin
                k = k % (2 * MAXV);
                r = (k <= MAXV) ? k : 2 * MAXV - k;
            end
            2:       r = k % (MAXV + 1);
            3:       r = (k % 2 == 1) ? m_lvl[i] : 0;
            default: r = m_lvl[i];
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_mode[i] = 0;
            m_rate[i] = 0;
            m_lvl[i]  = 0;
            m_t[i]    = 0;
            m_duty[i] = 0;
        end
        m_cnt = 0;
        m_pwm = '0;
        m_err = 1'b0;
        m_ps  = 1'b0;
    endtask

    always @(posedge clk) begin : model
        exp_t e;
        int   lv_old [CH];
        logic wrap;
        if (!rstb) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) lv_old[i] = level_of(i);
            wrap = ena && step && (m_cnt == MAXV - 1);
            if (ena) for (int i = 0; i < CH; i++) m_pwm[i] = (m_cnt < m_duty[i]);
            if (wrap) for (int i = 0; i < CH; i++) m_duty[i] = lv_old[i];
            m_ps = wrap;
            if (ena && step) m_cnt = (m_cnt + 1) % MAXV;
            m_err = cfg_wr && (int'(cfg_ch) >= CH);
            for (int i = 0; i < CH; i++) begin
                if (cfg_wr && int'(cfg_ch) == i) begin
                    m_mode[i] = int'(cfg_mode);
                    m_rate[i] = int'(cfg_rate);
                    m_lvl[i]  = int'(cfg_level);
                    m_t[i]    = 0;
                end else if (sync && ena && m_mode[i] != 0) begin
                    m_t[i] = 0;
                end else if (ena && fade_tick) begin
                    m_t[i]++;
                end
            end
        end
        for (int i = 0; i < CH; i++) e.levels[i*W +: W] = W'(level_of(i));
        e.pwm = m_pwm;
        e.err = m_err;
        e.ps  = m_ps;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_levels", levels, e.levels);
            check("sb_pwm_out", pwm_out, e.pwm);
            check("sb_cfg_err", cfg_err, e.err);
            check("sb_period_start", period_start, e.ps);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_cfg(input int ch, input int md, input int rt, input int lv);
        cfg_ch    = 4'(ch);
        cfg_mode  = 2'(md);
        cfg_rate  = RW'(rt);
        cfg_level = W'(lv);
        cfg_wr    = 1'b1;
        @(negedge clk);
        cfg_wr    = 1'b0;
    endtask

    task automatic duty_test(input int lv);
        int n;
        write_cfg(3, 0, 0, lv);
        check($sformatf("const_level_%0d", lv), levels[15:12], lv);
        idle(40);
        n = 0;
        repeat (MAXV) begin
            @(negedge clk);
            n += int'(pwm_out[3]);
        end
        check($sformatf("duty_highs_%0d", lv), n, lv);
    endtask

    initial begin
        rstb = 1'b1; ena = 1'b0; step = 1'b0; fade_tick = 1'b0; sync = 1'b0; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_rate = '0; cfg_level = '0;
        #1 rstb = 1'b0;
        #1;
        check("rst_levels", levels, 0);
        check("rst_pwm_out", pwm_out, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_period_start", period_start, 0);
        idle(2);
        rstb = 1'b1;
        ena = 1'b1; step = 1'b1; fade_tick = 1'b1;

        // Triangle, rate 0: 0..15..0 over 30 steps
        write_cfg(0, 1, 0, 0);
        check("tri_start", levels[3:0], 0);
        idle(15); check("tri_peak", levels[3:0], 15);
        idle(1);  check("tri_after_peak", levels[3:0], 14);
        idle(14); check("tri_floor", levels[3:0], 0);
        idle(1);  check("tri_rise", levels[3:0], 1);

        // Saw, rate 2: one step per three ticks, 15 wraps to 0
        write_cfg(1, 2, 2, 0);
        check("saw_start", levels[7:4], 0);
        idle(3);  check("saw_first", levels[7:4], 1);
        idle(44); check("saw_top", levels[7:4], 15);
        idle(1);  check("saw_wrap", levels[7:4], 0);

        // Blink at level 9
        write_cfg(2, 3, 0, 9);
        check("blink_0", levels[11:8], 0);
        idle(1); check("blink_1", levels[11:8], 9);
        idle(1); check("blink_2", levels[11:8], 0);
        idle(1); check("blink_3", levels[11:8], 9);

        duty_test(8);
        duty_test(0);
        duty_test(15);

        // Out-of-range channels
        write_cfg(5, 1, 0, 3);
        check("err_ch5_pulse", cfg_err, 1);
        idle(1); check("err_ch5_clear", cfg_err, 0);
        write_cfg(4, 2, 1, 7);
        check("err_ch4_pulse", cfg_err, 1);
        idle(1); check("err_ch4_clear", cfg_err, 0);

        // Asynchronous reset while ch3 drives high
        check("pre_rst_pwm3", pwm_out[3], 1);
        #2 rstb = 1'b0;
        #1;
        check("async_rst_pwm_out", pwm_out, 0);
        check("async_rst_levels", levels, 0);
        idle(2);
        rstb = 1'b1;
        idle(10);
        check("post_rst_levels", levels, 0);
        check("post_rst_pwm_out", pwm_out, 0);

        // Offset triangles, then sync together with a write to ch2
        write_cfg(0, 1, 0, 0);
        idle(7);
        write_cfg(1, 1, 0, 0);
        idle(4);
        cfg_ch = 4'd2; cfg_mode = 2'd2; cfg_rate = '0; cfg_level = '0;
        cfg_wr = 1'b1; sync = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0; sync = 1'b0;
        check("sync_ch0", levels[3:0], 0);
        check("sync_ch1", levels[7:4], 0);
        check("sync_ch2", levels[11:8], 0);
        idle(5);
        check("lock_ch0", levels[3:0], 5);
        check("lock_ch1", levels[7:4], 5);
        check("lock_ch2", levels[11:8], 5);

        // Freeze
        ena = 1'b0;
        repeat (20) begin
            step      = 1'($urandom_range(0, 1));
            fade_tick = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("freeze_ch0", levels[3:0], 5);
        check("freeze_ch1", levels[7:4], 5);
        check("freeze_ch2", levels[11:8], 5);

        // Randomised traffic against the model
        repeat (3000) begin
            ena       = ($urandom_range(0, 9) != 0);
            step      = ($urandom_range(0, 3) != 0);
            fade_tick = 1'($urandom_range(0, 1));
            sync      = ($urandom_range(0, 49) == 0);
            cfg_wr    = ($urandom_range(0, 19) == 0);
            cfg_ch    = 4'($urandom_range(0, 5));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_rate  = RW'($urandom_range(0, 3));
            cfg_level = W'($urandom_range(0, MAXV));
            @(negedge clk);
        end
        cfg_wr = 1'b0; sync = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
